// File: rtl/key_event_pkg.sv
// Shared types and width helpers for the key event encoder.
package key_event_pkg;

  // Event kind carried alongside Code; KIND_NONE is never presented with Valid.
  typedef enum logic [1:0] {
    KIND_NONE    = 2'd0,
    KIND_PRESS   = 2'd1,
    KIND_RELEASE = 2'd2,
    KIND_REPEAT  = 2'd3
  } kind_t;

  // Width of the key index; a single key still gets a one-bit code.
  function automatic int code_width(input int size);
    return (size <= 1) ? 1 : $clog2(size);
  endfunction

  // Width of a repeat timer that must hold values up to RepeatDelay.
  function automatic int timer_width(input int repeat_delay);
    return $clog2(repeat_delay + 1);
  endfunction

endpackage

// File: rtl/key_event_encoder_if.sv
// Event stream between the encoder and the downstream controller.
//
// Handshake: an event transfers on every rising Clock where Valid && Ready.
// The producer keeps Code/Kind stable and Valid high until that transfer;
// the consumer may drive Ready at any time, independent of Valid.
interface key_event_encoder_if #(
  parameter int CW = 2
) ();
  import key_event_pkg::*;

  logic          Valid;
  logic          Ready;
  logic [CW-1:0] Code;
  kind_t         Kind;

  modport master (output Valid, output Code, output Kind, input Ready);
  modport slave  (input Valid, input Code, input Kind, output Ready);

endinterface

// File: rtl/SelectNPulse.sv
// Free-running divider: one-clock Pulse every N clocks, counting from reset.
module SelectNPulse #(
  parameter int N = 2
) (
  input  logic Clock,
  input  logic nReset,
  output logic Pulse
);

  localparam int CNTW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);

  logic [CNTW-1:0] cnt;

  // Wrap-around counter; Pulse marks the last count of each period.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign Pulse = (cnt == LAST);

endmodule

// File: rtl/key_repeat_timer.sv
// Per-key auto-repeat timer. Counts Tick pulses while the key is held and
// fires on the tick after the count reaches RepeatDelay-1, then reloads so
// later repeats come every RepeatPeriod ticks.
module key_repeat_timer
  import key_event_pkg::*;
#(
  parameter int RepeatDelay  = 500,
  parameter int RepeatPeriod = 100
) (
  input  logic Clock,
  input  logic nReset,
  input  logic Tick,
  input  logic Held,
  input  logic Clear,
  output logic Fire
);

  localparam int TW = timer_width(RepeatDelay);
  localparam logic [TW-1:0] LAST   = TW'(RepeatDelay - 1);
  localparam logic [TW-1:0] RELOAD = TW'(RepeatDelay - RepeatPeriod);

  logic [TW-1:0] cnt;

  // Fire is combinational so the pending flag is set in the same clock as the tick.
  assign Fire = Tick & Held & ~Clear & (cnt == LAST);

  // Count ticks while held; a new press or a released key restarts from zero.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cnt <= '0;
    end else if (Clear || !Held) begin
      cnt <= '0;
    end else if (Tick) begin
      cnt <= (cnt == LAST) ? RELOAD : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// Key event encoder: turns debounced active-low key levels into a serial
// stream of press / release / auto-repeat events with a sticky overrun flag.
module key_event_encoder
  import key_event_pkg::*;
#(
  parameter int Size           = 4,
  parameter int ClockPeriod_ns = 20,
  parameter int TickPeriod_ns  = 1_000_000,
  parameter int RepeatDelay    = 500,
  parameter int RepeatPeriod   = 100
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic [Size-1:0]     I,
  key_event_encoder_if.master Ev,
  output logic [Size-1:0]     Held,
  output logic                Overrun
);

  localparam int CW    = code_width(Size);
  localparam int TickN = TickPeriod_ns / ClockPeriod_ns;

  logic [Size-1:0] prev;
  logic [Size-1:0] key_down;
  logic [Size-1:0] prs_edge;
  logic [Size-1:0] rel_edge;
  logic [Size-1:0] fire;
  logic            tick;

  logic [Size-1:0] pp, pr, pt;
  logic [Size-1:0] pp_nxt, pr_nxt, pt_nxt;
  logic [Size-1:0] clr_pp, clr_pr, clr_pt;
  logic            ovr_set;

  logic            sel_any;
  logic [CW-1:0]   sel_idx;
  kind_t           sel_kind;
  logic [Size-1:0] sel_oh;
  logic            load;

  logic            valid_q;
  logic [CW-1:0]   code_q;
  kind_t           kind_q;
  logic            overrun_q;

  // Repeat tick source; a tick period of one clock or less ticks every clock.
  generate
    if (TickN <= 1) begin : g_tick_const
      assign tick = 1'b1;
    end else begin : g_tick_div
      SelectNPulse #(.N(TickN)) u_tick (
        .Clock  (Clock),
        .nReset (nReset),
        .Pulse  (tick)
      );
    end
  endgenerate

  // Previous key levels; reset to idle so a key held through reset yields a Press.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      prev <= '1;
    end else begin
      prev <= I;
    end
  end

  assign key_down = ~I;
  assign prs_edge = prev & ~I;
  assign rel_edge = ~prev & I;
  assign Held     = ~prev;

  // One repeat timer per key.
  for (genvar g = 0; g < Size; g++) begin : g_timer
    key_repeat_timer #(
      .RepeatDelay  (RepeatDelay),
      .RepeatPeriod (RepeatPeriod)
    ) u_timer (
      .Clock  (Clock),
      .nReset (nReset),
      .Tick   (tick),
      .Held   (key_down[g]),
      .Clear  (prs_edge[g]),
      .Fire   (fire[g])
    );
  end

  // Priority pick: lowest key with anything pending; within a key PP, PR, PT.
  always_comb begin
    sel_any  = 1'b0;
    sel_idx  = '0;
    sel_kind = KIND_NONE;
    sel_oh   = '0;
    for (int i = Size - 1; i >= 0; i--) begin
      if (pp[i] || pr[i] || pt[i]) begin
        sel_any   = 1'b1;
        sel_idx   = CW'(i);
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        if (pp[i]) begin
          sel_kind = KIND_PRESS;
        end else if (pr[i]) begin
          sel_kind = KIND_RELEASE;
        end else begin
          sel_kind = KIND_REPEAT;
        end
      end
    end
  end

  assign load = ~valid_q | Ev.Ready;

  // Pending-flag update: the loaded flag clears, a new edge in the same clock
  // wins over that clear, and setting an already-pending flag is an overrun.
  always_comb begin
    clr_pp  = (load && sel_kind == KIND_PRESS)   ? sel_oh : '0;
    clr_pr  = (load && sel_kind == KIND_RELEASE) ? sel_oh : '0;
    clr_pt  = (load && sel_kind == KIND_REPEAT)  ? sel_oh : '0;
    pp_nxt  = (pp & ~clr_pp) | prs_edge;
    pr_nxt  = (pr & ~clr_pr) | rel_edge;
    pt_nxt  = ((pt & ~clr_pt) | fire) & ~rel_edge;
    ovr_set = |(prs_edge & pp & ~clr_pp)
            | |(rel_edge & pr & ~clr_pr)
            | |(fire & pt & ~clr_pt);
  end

  // Pending flag registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pp <= '0;
      pr <= '0;
      pt <= '0;
    end else begin
      pp <= pp_nxt;
      pr <= pr_nxt;
      pt <= pt_nxt;
    end
  end

  // Output register: loads when empty or accepted; Code/Kind hold when idle.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      kind_q  <= KIND_NONE;
    end else if (load) begin
      valid_q <= sel_any;
      if (sel_any) begin
        code_q <= sel_idx;
        kind_q <= sel_kind;
      end
    end
  end

  // Sticky overrun, cleared only by reset.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      overrun_q <= 1'b0;
    end else if (ovr_set) begin
      overrun_q <= 1'b1;
    end
  end

  assign Ev.Valid = valid_q;
  assign Ev.Code  = code_q;
  assign Ev.Kind  = kind_q;
  assign Overrun  = overrun_q;

endmodule
